uart_word_assembler: RTL and testbench

- Debug-unit block that rebuilds 32-bit instruction words from the UART receiver byte stream. It is the inverse of a 4:1 word select: one byte lane fans out into four byte slots of a word.
- Each completed word goes out with a write strobe and a word address. The consumer is the instruction-memory load port, used while the pipeline is held in load mode.
- Loading ends on the HALT word or when the address space is exhausted.

---
 rtl/uart_word_assembler.sv | 140 ++++++++++++++
 tb/tb_uart_word_assembler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// Rebuilds little-endian instruction words from a UART byte stream and emits
// one write strobe per word until HALT_WORD arrives or the address space runs out.
module uart_word_assembler #(
  parameter int                   DATA_SIZE = 32,
  parameter int                   BYTE_SIZE = 8,
  parameter int                   ADDR_SIZE = 8,
  parameter logic [DATA_SIZE-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_rx_done,
  input  logic [BYTE_SIZE-1:0] i_rx_data,
  output logic [DATA_SIZE-1:0] o_word,
  output logic                 o_word_valid,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic [1:0]           o_byte_idx,
  output logic                 o_load_done,
  output logic                 o_overflow
);

  // state   | meaning
  // IDLE    | load mode off, bytes ignored
  // COLLECT | filling byte slots, emitting words
  // DONE    | HALT seen or capacity hit, outputs frozen
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE-1:0] ADDR_MAX = '1;

  state_t                   state_q, state_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [3*BYTE_SIZE-1:0]   buf_q, buf_d;
  logic [DATA_SIZE-1:0]     word_q, word_d;
  logic                     word_valid_q, word_valid_d;
  logic [ADDR_SIZE-1:0]     addr_q, addr_d;
  logic                     load_done_q, load_done_d;
  logic                     overflow_q, overflow_d;
  logic                     terminate;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    buf_d        = buf_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    addr_d       = addr_q;
    load_done_d  = load_done_q;
    overflow_d   = overflow_q;
    terminate    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d     = COLLECT;
          byte_idx_d  = 2'd0;
          addr_d      = '0;
          load_done_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end

      COLLECT: begin
        if (!i_enable) begin
          state_d    = IDLE;
          byte_idx_d = 2'd0;
        end else begin
          // Address step / termination happens at the edge closing the strobe cycle.
          if (word_valid_q) begin
            if (word_q == HALT_WORD) begin
              terminate   = 1'b1;
              state_d     = DONE;
              load_done_d = 1'b1;
              if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
            end else if (addr_q == ADDR_MAX) begin
              terminate   = 1'b1;
              state_d     = DONE;
              load_done_d = 1'b1;
              overflow_d  = 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end

          if (i_rx_done && !terminate) begin
            case (byte_idx_q)
              2'd0: buf_d[0*BYTE_SIZE +: BYTE_SIZE] = i_rx_data;
              2'd1: buf_d[1*BYTE_SIZE +: BYTE_SIZE] = i_rx_data;
              2'd2: buf_d[2*BYTE_SIZE +: BYTE_SIZE] = i_rx_data;
              default: begin
                word_d       = {i_rx_data, buf_q};
                word_valid_d = 1'b1;
              end
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      DONE: begin
        if (!i_enable) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      byte_idx_q   <= 2'd0;
      buf_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      addr_q       <= '0;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      buf_q        <= buf_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      addr_q       <= addr_d;
      load_done_q  <= load_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = word_valid_q;
  assign o_addr       = addr_q;
  assign o_byte_idx   = byte_idx_q;
  assign o_load_done  = load_done_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: default instance plus a 4-word
// instance for capacity limits, with a scoreboard of expected word writes.
module tb_uart_word_assembler;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en2;
  logic        rx_done;
  logic [7:0]  rx_data;

  logic [31:0] word_a, word_b;
  logic        valid_a, valid_b;
  logic [7:0]  addr_a;
  logic [1:0]  addr_b;
  logic [1:0]  bidx_a, bidx_b;
  logic        done_a, done_b, ovf_a, ovf_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cyc_prev = 0;
  int valid_cyc_last = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word_assembler u_dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_word(word_a), .o_word_valid(valid_a), .o_addr(addr_a), .o_byte_idx(bidx_a),
    .o_load_done(done_a), .o_overflow(ovf_a)
  );

  uart_word_assembler #(.ADDR_SIZE(2)) u_small (
    .i_clk(clk), .i_reset(rst), .i_enable(en2), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_word(word_b), .o_word_valid(valid_b), .o_addr(addr_b), .o_byte_idx(bidx_b),
    .o_load_done(done_b), .o_overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (valid_a) begin
      valid_cyc_prev = valid_cyc_last;
      valid_cyc_last = cyc;
      chk("a_valid_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_word", word_a, e.word);
        chk("a_addr", 32'(addr_a), 32'(e.addr));
      end
    end
    if (valid_b) begin
      chk("b_valid_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("b_word", word_b, e.word);
        chk("b_addr", 32'(addr_b), 32'(e.addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_done = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
  endtask

  // Four consecutive strobes, little-endian; leaves rx_done high for chaining.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_a(input logic [7:0] a, input logic [31:0] w);
    wr_t e;
    e.addr = a;
    e.word = w;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] a, input logic [31:0] w);
    wr_t e;
    e.addr = a;
    e.word = w;
    exp_b.push_back(e);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en2 = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_word", word_a, 32'h0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_byte_idx", 32'(bidx_a), 32'd0);
    chk("rst_flags", {30'd0, done_a, ovf_a}, 32'd0);

    // basic assembly with gaps between strobes
    en = 1'b1;
    idle(1);
    push_a(8'd0, 32'h20200013);
    send_byte(8'h13); idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'h20); idle(1);
    chk("basic_byte_idx_mid", 32'(bidx_a), 32'd3);
    send_byte(8'h20); idle(1);
    chk("basic_addr_after", 32'(addr_a), 32'd1);
    chk("basic_byte_idx_after", 32'(bidx_a), 32'd0);
    chk("basic_word_hold", word_a, 32'h20200013);

    // back-to-back strobes across two words
    en = 1'b0; idle(1);
    en = 1'b1; idle(1);
    chk("b2b_addr_start", 32'(addr_a), 32'd0);
    push_a(8'd0, 32'h00000001);
    push_a(8'd1, 32'h00000002);
    send_word(32'h00000001);
    send_word(32'h00000002);
    idle(2);
    chk("b2b_pulse_spacing", 32'(valid_cyc_last - valid_cyc_prev), 32'd4);
    chk("b2b_addr_after", 32'(addr_a), 32'd2);
    chk("b2b_byte_idx", 32'(bidx_a), 32'd0);

    // HALT termination
    en = 1'b0; idle(1);
    en = 1'b1; idle(1);
    push_a(8'd0, 32'h8C010004);
    push_a(8'd1, 32'hFFFFFFFF);
    send_word(32'h8C010004);
    send_word(32'hFFFFFFFF);
    idle(2);
    chk("halt_done", 32'(done_a), 32'd1);
    chk("halt_ovf", 32'(ovf_a), 32'd0);
    chk("halt_addr", 32'(addr_a), 32'd2);
    send_word(32'h11223344);
    idle(3);
    chk("halt_ignore_byte_idx", 32'(bidx_a), 32'd0);
    chk("halt_ignore_word", word_a, 32'hFFFFFFFF);
    en = 1'b0; idle(1);
    chk("halt_flag_sticky_idle", 32'(done_a), 32'd1);
    en = 1'b1; idle(1);
    chk("halt_flag_cleared", 32'(done_a), 32'd0);
    chk("halt_addr_cleared", 32'(addr_a), 32'd0);

    // reset mid-word
    send_byte(8'h11);
    send_byte(8'h22);
    rx_done = 1'b0;
    rst = 1'b1; idle(1);
    rst = 1'b0; idle(1);
    chk("rstmid_word", word_a, 32'h0);
    chk("rstmid_byte_idx", 32'(bidx_a), 32'd0);
    push_a(8'd0, 32'hDDCCBBAA);
    send_word(32'hDDCCBBAA);
    idle(2);
    chk("rstmid_addr", 32'(addr_a), 32'd1);

    // enable drop mid-word
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rx_done = 1'b0;
    en = 1'b0; idle(1);
    chk("endrop_byte_idx", 32'(bidx_a), 32'd0);
    en = 1'b1; idle(1);
    chk("endrop_addr", 32'(addr_a), 32'd0);
    chk("endrop_flags", {30'd0, done_a, ovf_a}, 32'd0);
    push_a(8'd0, 32'h77665544);
    send_word(32'h77665544);
    idle(2);

    // reset wins over a simultaneous strobe
    rst = 1'b1;
    send_byte(8'h55);
    rst = 1'b0;
    idle(1);
    chk("rst_vs_strobe_byte_idx", 32'(bidx_a), 32'd0);
    send_byte(8'h66);
    idle(1);
    chk("post_rst_capture", 32'(bidx_a), 32'd1);

    // capacity overflow on the 4-word instance
    en = 1'b0;
    en2 = 1'b1; idle(1);
    for (int i = 0; i < 4; i++) begin
      push_b(8'(i), 32'h10 + 32'(i));
      send_word(32'h10 + 32'(i));
    end
    idle(2);
    chk("ovf_done", 32'(done_b), 32'd1);
    chk("ovf_flag", 32'(ovf_b), 32'd1);
    chk("ovf_addr_hold", 32'(addr_b), 32'd3);
    send_word(32'h00000014);
    idle(3);
    chk("ovf_5th_ignored_word", word_b, 32'h00000013);
    chk("ovf_5th_ignored_addr", 32'(addr_b), 32'd3);

    // HALT exactly at the last address is not an overflow
    en2 = 1'b0; idle(1);
    en2 = 1'b1; idle(1);
    chk("ovf_flag_cleared", 32'(ovf_b), 32'd0);
    for (int i = 0; i < 3; i++) begin
      push_b(8'(i), 32'h20 + 32'(i));
      send_word(32'h20 + 32'(i));
    end
    push_b(8'd3, 32'hFFFFFFFF);
    send_word(32'hFFFFFFFF);
    idle(2);
    chk("halt_max_done", 32'(done_b), 32'd1);
    chk("halt_max_ovf", 32'(ovf_b), 32'd0);
    chk("halt_max_addr", 32'(addr_b), 32'd3);

    idle(2);
    chk("scoreboard_a_empty", 32'(exp_a.size()), 32'd0);
    chk("scoreboard_b_empty", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
